// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: address map, bit positions,
// interrupt causes and reset values.
package csr_pkg;

  localparam logic [11:0] CsrMstatus       = 12'h300;
  localparam logic [11:0] CsrMisa          = 12'h301;
  localparam logic [11:0] CsrMie           = 12'h304;
  localparam logic [11:0] CsrMtvec         = 12'h305;
  localparam logic [11:0] CsrMcountinhibit = 12'h320;
  localparam logic [11:0] CsrMscratch      = 12'h340;
  localparam logic [11:0] CsrMepc          = 12'h341;
  localparam logic [11:0] CsrMcause        = 12'h342;
  localparam logic [11:0] CsrMtval         = 12'h343;
  localparam logic [11:0] CsrMip           = 12'h344;
  localparam logic [11:0] CsrMcycle        = 12'hB00;
  localparam logic [11:0] CsrMinstret      = 12'hB02;
  localparam logic [11:0] CsrMcycleh       = 12'hB80;
  localparam logic [11:0] CsrMinstreth     = 12'hB82;
  localparam logic [11:0] CsrCycle         = 12'hC00;
  localparam logic [11:0] CsrInstret       = 12'hC02;
  localparam logic [11:0] CsrCycleh        = 12'hC80;
  localparam logic [11:0] CsrInstreth      = 12'hC82;
  localparam logic [11:0] CsrMhartid       = 12'hF14;

  localparam int MstatusMie  = 3;
  localparam int MstatusMpie = 7;
  localparam int IrqSoft     = 3;
  localparam int IrqTimer    = 7;
  localparam int IrqExt      = 11;

  localparam logic [31:0] CauseExt   = 32'h8000_000B;
  localparam logic [31:0] CauseSoft  = 32'h8000_0003;
  localparam logic [31:0] CauseTimer = 32'h8000_0007;

  localparam logic [1:0]  MstatusMppRst = 2'b11;
  localparam logic [31:0] IrqMask       = 32'h0000_0888;
  localparam logic [31:0] InhibitMask   = 32'h0000_0005;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with inhibit and independently writable halves.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  input  logic        inhibit_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q, count_d;

  // A write to either half suppresses the increment for that cycle.
  always_comb begin
    count_d = count_q;
    if (wr_lo_i) begin
      count_d[31:0] = wdata_i;
    end else if (wr_hi_i) begin
      count_d[63:32] = wdata_i;
    end else if (inc_i && !inhibit_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/reg_csr_unit.sv
// Machine-mode CSR file with trap/MRET handling, counters, interrupt arbitration
// and a pipelined, forwarded read path.
module reg_csr_unit import csr_pkg::*; #(
  parameter logic [31:0] MHARTID    = 32'h0,
  parameter logic [31:0] MISA_VAL   = 32'h4000_0100,
  parameter logic [31:0] MTVEC_RST  = 32'h0,
  parameter bit          CYCLE_EN   = 1'b1,
  parameter bit          INSTRET_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        FLUSH,
  input  logic        STALL,
  input  logic        MMU_WAIT,
  input  logic        TRAP_EN,
  input  logic [31:0] TRAP_CODE,
  input  logic [31:0] TRAP_PC,
  input  logic [31:0] TRAP_VAL,
  output logic [1:0]  TRAP_VEC_MODE,
  output logic [31:0] TRAP_VEC_BASE,
  input  logic        CHMODE_DO,
  output logic [31:0] RET_PC,
  input  logic        INT_EXT,
  input  logic        INT_TIMER,
  input  logic        INT_SOFT,
  output logic        INT_PENDING,
  output logic [31:0] INT_CAUSE,
  input  logic        RETIRE,
  input  logic [11:0] RADDR,
  output logic        RVALID,
  output logic [31:0] RDATA,
  output logic        RILLEGAL,
  input  logic        WREN,
  input  logic [11:0] WADDR,
  input  logic [31:0] WDATA,
  input  logic [11:0] FWD_CSR_ADDR,
  input  logic        FWD_EXEC_EN,
  input  logic [11:0] FWD_EXEC_ADDR,
  input  logic [31:0] FWD_EXEC_DATA,
  input  logic        FWD_CUSHION_EN,
  input  logic [11:0] FWD_CUSHION_ADDR,
  input  logic [31:0] FWD_CUSHION_DATA
);

  logic        wr_ok;
  logic [11:0] raddr_q, waddr_q, fwd_csr_addr_q, fwd_exec_addr_q, fwd_cush_addr_q;
  logic [31:0] wdata_q, fwd_exec_data_q, fwd_cush_data_q;
  logic        wren_q, fwd_exec_en_q, fwd_cush_en_q;

  assign wr_ok = WREN & ~TRAP_EN & ~CHMODE_DO;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N || FLUSH) begin
      raddr_q         <= '0;
      waddr_q         <= '0;
      wdata_q         <= '0;
      wren_q          <= 1'b0;
      fwd_csr_addr_q  <= '0;
      fwd_exec_en_q   <= 1'b0;
      fwd_exec_addr_q <= '0;
      fwd_exec_data_q <= '0;
      fwd_cush_en_q   <= 1'b0;
      fwd_cush_addr_q <= '0;
      fwd_cush_data_q <= '0;
    end else if (!MMU_WAIT || STALL) begin
      // STALL keeps the read/write capture but still tracks the forward sources.
      if (!STALL) begin
        raddr_q <= RADDR;
        waddr_q <= WADDR;
        wdata_q <= WDATA;
        wren_q  <= wr_ok;
      end
      fwd_csr_addr_q  <= STALL ? 12'h000 : FWD_CSR_ADDR;
      fwd_exec_en_q   <= FWD_EXEC_EN;
      fwd_exec_addr_q <= FWD_EXEC_ADDR;
      fwd_exec_data_q <= FWD_EXEC_DATA;
      fwd_cush_en_q   <= FWD_CUSHION_EN;
      fwd_cush_addr_q <= FWD_CUSHION_ADDR;
      fwd_cush_data_q <= FWD_CUSHION_DATA;
    end
  end

  logic        st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, minh_q, minh_d;
  logic [31:0] mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [2:0]  irq_q;  // {ext, timer, soft}

  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    minh_d     = minh_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (TRAP_EN) begin
      mcause_d  = TRAP_CODE;
      mepc_d    = {TRAP_PC[31:2], 2'b00};
      mtval_d   = TRAP_VAL;
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end else if (CHMODE_DO) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end else if (WREN) begin
      case (WADDR)
        CsrMstatus: begin
          st_mie_d  = WDATA[MstatusMie];
          st_mpie_d = WDATA[MstatusMpie];
        end
        CsrMie:           mie_d      = WDATA & IrqMask;
        // Reserved vector modes 2/3 fall back to direct mode.
        CsrMtvec:         mtvec_d    = {WDATA[31:2], WDATA[1] ? 2'b00 : WDATA[1:0]};
        CsrMcountinhibit: minh_d     = WDATA & InhibitMask;
        CsrMscratch:      mscratch_d = WDATA;
        CsrMepc:          mepc_d     = {WDATA[31:2], 2'b00};
        CsrMcause:        mcause_d   = WDATA;
        CsrMtval:         mtval_d    = WDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      minh_q     <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      irq_q      <= '0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      minh_q     <= minh_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      irq_q      <= {INT_EXT, INT_TIMER, INT_SOFT};
    end
  end

  logic [63:0] mcycle, minstret;

  if (CYCLE_EN) begin : g_mcycle
    csr_counter64 u_mcycle (
      .clk_i    (CLK),
      .rst_ni   (RST_N),
      .inc_i    (1'b1),
      .inhibit_i(minh_q[0]),
      .wr_lo_i  (wr_ok && (WADDR == CsrMcycle)),
      .wr_hi_i  (wr_ok && (WADDR == CsrMcycleh)),
      .wdata_i  (WDATA),
      .count_o  (mcycle)
    );
  end else begin : g_no_mcycle
    assign mcycle = '0;
  end

  if (INSTRET_EN) begin : g_minstret
    csr_counter64 u_minstret (
      .clk_i    (CLK),
      .rst_ni   (RST_N),
      .inc_i    (RETIRE),
      .inhibit_i(minh_q[2]),
      .wr_lo_i  (wr_ok && (WADDR == CsrMinstret)),
      .wr_hi_i  (wr_ok && (WADDR == CsrMinstreth)),
      .wdata_i  (WDATA),
      .count_o  (minstret)
    );
  end else begin : g_no_minstret
    assign minstret = '0;
  end

  logic [31:0] arch_rdata;
  logic        addr_ok;

  always_comb begin
    arch_rdata = '0;
    addr_ok    = 1'b1;
    case (raddr_q)
      CsrMstatus: arch_rdata = {19'b0, MstatusMppRst, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
      CsrMisa:          arch_rdata = MISA_VAL;
      CsrMie:           arch_rdata = mie_q;
      CsrMtvec:         arch_rdata = mtvec_q;
      CsrMcountinhibit: arch_rdata = minh_q;
      CsrMscratch:      arch_rdata = mscratch_q;
      CsrMepc:          arch_rdata = mepc_q;
      CsrMcause:        arch_rdata = mcause_q;
      CsrMtval:         arch_rdata = mtval_q;
      CsrMip:           arch_rdata = {20'b0, irq_q[2], 3'b0, irq_q[1], 3'b0, irq_q[0], 3'b0};
      CsrMcycle, CsrCycle:       arch_rdata = mcycle[31:0];
      CsrMcycleh, CsrCycleh:     arch_rdata = mcycle[63:32];
      CsrMinstret, CsrInstret:   arch_rdata = minstret[31:0];
      CsrMinstreth, CsrInstreth: arch_rdata = minstret[63:32];
      CsrMhartid:       arch_rdata = MHARTID;
      default:          addr_ok    = 1'b0;
    endcase
  end

  always_comb begin
    RVALID   = 1'b1;
    RDATA    = arch_rdata;
    RILLEGAL = 1'b0;
    if (raddr_q == 12'h000) begin
      RDATA = '0;
    end else begin
      if (raddr_q == fwd_csr_addr_q) begin
        RVALID = 1'b0;
      end else if (raddr_q == fwd_exec_addr_q) begin
        RVALID = fwd_exec_en_q;
        RDATA  = fwd_exec_data_q;
      end else if (raddr_q == fwd_cush_addr_q) begin
        RVALID = fwd_cush_en_q;
        RDATA  = fwd_cush_data_q;
      end else if (wren_q && (raddr_q == waddr_q)) begin
        RDATA = wdata_q;
      end
      if (!addr_ok) begin
        RDATA    = '0;
        RILLEGAL = 1'b1;
      end
    end
  end

  logic [2:0] irq_act;  // {ext, timer, soft}

  assign irq_act     = irq_q & {mie_q[IrqExt], mie_q[IrqTimer], mie_q[IrqSoft]};
  assign INT_PENDING = st_mie_q & (|irq_act);

  always_comb begin
    INT_CAUSE = '0;
    if (INT_PENDING) begin
      if (irq_act[2]) begin
        INT_CAUSE = CauseExt;
      end else if (irq_act[0]) begin
        INT_CAUSE = CauseSoft;
      end else begin
        INT_CAUSE = CauseTimer;
      end
    end
  end

  assign TRAP_VEC_MODE = mtvec_q[1:0];
  assign TRAP_VEC_BASE = {mtvec_q[31:2], 2'b00};
  assign RET_PC        = mepc_q;

endmodule

// File: tb/tb_reg_csr_unit.sv
// Self-checking bench for reg_csr_unit: a behavioural model checked every cycle
// plus directed scenarios with hand-computed expectations.
module tb_reg_csr_unit;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        FLUSH = 0, STALL = 0, MMU_WAIT = 0, TRAP_EN = 0, CHMODE_DO = 0;
  logic [31:0] TRAP_CODE = 0, TRAP_PC = 0, TRAP_VAL = 0;
  logic [1:0]  TRAP_VEC_MODE;
  logic [31:0] TRAP_VEC_BASE, RET_PC, INT_CAUSE, RDATA;
  logic        INT_EXT = 0, INT_TIMER = 0, INT_SOFT = 0, INT_PENDING;
  logic        RETIRE = 0, RVALID, RILLEGAL, WREN = 0;
  logic [11:0] RADDR = 0, WADDR = 0, FWD_CSR_ADDR = 0, FWD_EXEC_ADDR = 0, FWD_CUSHION_ADDR = 0;
  logic [31:0] WDATA = 0, FWD_EXEC_DATA = 0, FWD_CUSHION_DATA = 0;
  logic        FWD_EXEC_EN = 0, FWD_CUSHION_EN = 0;

  int n_total = 0;
  int n_bad = 0;

  reg_csr_unit dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .STALL(STALL), .MMU_WAIT(MMU_WAIT),
    .TRAP_EN(TRAP_EN), .TRAP_CODE(TRAP_CODE), .TRAP_PC(TRAP_PC), .TRAP_VAL(TRAP_VAL),
    .TRAP_VEC_MODE(TRAP_VEC_MODE), .TRAP_VEC_BASE(TRAP_VEC_BASE), .CHMODE_DO(CHMODE_DO),
    .RET_PC(RET_PC), .INT_EXT(INT_EXT), .INT_TIMER(INT_TIMER), .INT_SOFT(INT_SOFT),
    .INT_PENDING(INT_PENDING), .INT_CAUSE(INT_CAUSE), .RETIRE(RETIRE), .RADDR(RADDR),
    .RVALID(RVALID), .RDATA(RDATA), .RILLEGAL(RILLEGAL), .WREN(WREN), .WADDR(WADDR),
    .WDATA(WDATA), .FWD_CSR_ADDR(FWD_CSR_ADDR), .FWD_EXEC_EN(FWD_EXEC_EN),
    .FWD_EXEC_ADDR(FWD_EXEC_ADDR), .FWD_EXEC_DATA(FWD_EXEC_DATA),
    .FWD_CUSHION_EN(FWD_CUSHION_EN), .FWD_CUSHION_ADDR(FWD_CUSHION_ADDR),
    .FWD_CUSHION_DATA(FWD_CUSHION_DATA)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_mie, m_mpie;
  bit [31:0]   m_ie, m_tvec, m_inh, m_scratch, m_epc, m_cause, m_tval;
  bit [2:0]    m_ip;  // {ext, timer, soft}
  bit [63:0]   m_cyc, m_ret;
  bit [11:0]   m_raddr, m_waddr, m_fcsr, m_fe_addr, m_fc_addr;
  bit [31:0]   m_wdata, m_fe_data, m_fc_data;
  bit          m_wren, m_fe_en, m_fc_en;

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_ie = 0; m_tvec = 0; m_inh = 0; m_scratch = 0;
    m_epc = 0; m_cause = 0; m_tval = 0; m_ip = 0; m_cyc = 0; m_ret = 0;
    m_raddr = 0; m_waddr = 0; m_wdata = 0; m_wren = 0; m_fcsr = 0;
    m_fe_en = 0; m_fe_addr = 0; m_fe_data = 0; m_fc_en = 0; m_fc_addr = 0; m_fc_data = 0;
  endtask

  task automatic model_step();
    bit wr;
    bit [63:0] c, r;
    wr = WREN && !TRAP_EN && !CHMODE_DO;
    c = m_cyc;
    r = m_ret;
    if (wr && WADDR == 12'hB00) c[31:0] = WDATA;
    else if (wr && WADDR == 12'hB80) c[63:32] = WDATA;
    else if (!m_inh[0]) c = c + 64'd1;
    if (wr && WADDR == 12'hB02) r[31:0] = WDATA;
    else if (wr && WADDR == 12'hB82) r[63:32] = WDATA;
    else if (!m_inh[2] && RETIRE) r = r + 64'd1;
    if (TRAP_EN) begin
      m_cause = TRAP_CODE; m_epc = TRAP_PC & ~32'h3; m_tval = TRAP_VAL;
      m_mpie = m_mie; m_mie = 0;
    end else if (CHMODE_DO) begin
      m_mie = m_mpie; m_mpie = 1;
    end else if (wr) begin
      case (WADDR)
        12'h300: begin m_mie = WDATA[3]; m_mpie = WDATA[7]; end
        12'h304: m_ie = WDATA & 32'h888;
        12'h305: m_tvec = (WDATA[1:0] >= 2'd2) ? (WDATA & ~32'h3) : WDATA;
        12'h320: m_inh = WDATA & 32'h5;
        12'h340: m_scratch = WDATA;
        12'h341: m_epc = WDATA & ~32'h3;
        12'h342: m_cause = WDATA;
        12'h343: m_tval = WDATA;
        default: ;
      endcase
    end
    m_cyc = c;
    m_ret = r;
    m_ip = {INT_EXT, INT_TIMER, INT_SOFT};
    if (FLUSH) begin
      m_raddr = 0; m_waddr = 0; m_wdata = 0; m_wren = 0; m_fcsr = 0;
      m_fe_en = 0; m_fe_addr = 0; m_fe_data = 0; m_fc_en = 0; m_fc_addr = 0; m_fc_data = 0;
    end else if (STALL || !MMU_WAIT) begin
      if (!STALL) begin
        m_raddr = RADDR; m_waddr = WADDR; m_wdata = WDATA; m_wren = wr; m_fcsr = FWD_CSR_ADDR;
      end else begin
        m_fcsr = 0;
      end
      m_fe_en = FWD_EXEC_EN; m_fe_addr = FWD_EXEC_ADDR; m_fe_data = FWD_EXEC_DATA;
      m_fc_en = FWD_CUSHION_EN; m_fc_addr = FWD_CUSHION_ADDR; m_fc_data = FWD_CUSHION_DATA;
    end
  endtask

  task automatic arch_val(input bit [11:0] a, output bit [31:0] v, output bit ok);
    ok = 1;
    case (a)
      12'h300: v = 32'h1800 + (m_mie ? 32'h8 : 0) + (m_mpie ? 32'h80 : 0);
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_ie;
      12'h305: v = m_tvec;
      12'h320: v = m_inh;
      12'h340: v = m_scratch;
      12'h341: v = m_epc;
      12'h342: v = m_cause;
      12'h343: v = m_tval;
      12'h344: v = (m_ip[2] ? 32'h800 : 0) + (m_ip[1] ? 32'h80 : 0) + (m_ip[0] ? 32'h8 : 0);
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ret[31:0];
      12'hB82, 12'hC82: v = m_ret[63:32];
      12'hF14: v = 32'h0;
      default: begin v = 0; ok = 0; end
    endcase
  endtask

  task automatic exp_read(output bit v, output bit [31:0] d, output bit ill);
    bit ok;
    arch_val(m_raddr, d, ok);
    v = 1;
    ill = 0;
    if (m_raddr == 0) begin
      d = 0;
      return;
    end
    if (m_raddr == m_fcsr) v = 0;
    else if (m_raddr == m_fe_addr) begin v = m_fe_en; d = m_fe_data; end
    else if (m_raddr == m_fc_addr) begin v = m_fc_en; d = m_fc_data; end
    else if (m_wren && m_raddr == m_waddr) d = m_wdata;
    if (!ok) begin d = 0; ill = 1; end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    bit ev, eill, ep, se, ss;
    bit [31:0] ed, ec;
    forever begin
      @(negedge CLK);
      exp_read(ev, ed, eill);
      se = m_ip[2] && m_ie[11];
      ss = m_ip[0] && m_ie[3];
      ep = m_mie && (se || ss || (m_ip[1] && m_ie[7]));
      ec = !ep ? 32'h0 : se ? 32'h8000_000B : ss ? 32'h8000_0003 : 32'h8000_0007;
      chk("model_rvalid", {31'b0, RVALID}, {31'b0, ev});
      if (ev) chk("model_rdata", RDATA, ed);
      chk("model_rillegal", {31'b0, RILLEGAL}, {31'b0, eill});
      chk("model_int_pending", {31'b0, INT_PENDING}, {31'b0, ep});
      chk("model_int_cause", INT_CAUSE, ec);
      chk("model_ret_pc", RET_PC, m_epc);
      chk("model_vec_mode", {30'b0, TRAP_VEC_MODE}, {30'b0, m_tvec[1:0]});
      chk("model_vec_base", TRAP_VEC_BASE, m_tvec & ~32'h3);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    WREN = 1; WADDR = a; WDATA = d;
    tick();
    WREN = 0; WADDR = 0; WDATA = 0;
  endtask

  task automatic rd(input logic [11:0] a);
    RADDR = a;
    tick();
  endtask

  localparam logic [11:0] Sweep [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340,
    12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
    12'hC02, 12'hC82, 12'hF14, 12'h123};

  initial begin
    #1 RST_N = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rvalid", {31'b0, RVALID}, 32'h1);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_rillegal", {31'b0, RILLEGAL}, 32'h0);
    chk("rst_int_pending", {31'b0, INT_PENDING}, 32'h0);
    RST_N = 1;
    repeat (10) tick();
    rd(12'hB00);  chk("mcycle_first", RDATA, 32'd11);
    tick();       chk("mcycle_next", RDATA, 32'd12);
    rd(12'hB80);  chk("mcycleh_zero", RDATA, 32'h0);
    rd(12'h7C0);  chk("illegal_flag", {31'b0, RILLEGAL}, 32'h1);
                  chk("illegal_data", RDATA, 32'h0);

    // Carry from low into high half.
    wr(12'hB00, 32'hFFFF_FFFE);
    wr(12'hB80, 32'h0);
    rd(12'hB80);  chk("carry_hi_before", RDATA, 32'h0);
    tick();       chk("carry_hi_after", RDATA, 32'h1);
    rd(12'hB00);  chk("carry_lo_after", RDATA, 32'h1);
    wr(12'h320, 32'h1); chk("inhibit_last_inc", RDATA, 32'h2);
    tick();       chk("inhibit_frozen", RDATA, 32'h2);
    wr(12'h320, 32'h0);

    RETIRE = 1;
    repeat (3) tick();
    RETIRE = 0;
    rd(12'hB02);  chk("minstret", RDATA, 32'h3);
    rd(12'hC02);  chk("instret_shadow", RDATA, 32'h3);

    // Interrupts.
    wr(12'h340, 32'h0000_AAAA);
    wr(12'h300, 32'h8);
    wr(12'h304, 32'h888);
    INT_EXT = 1;
    #1 chk("irq_not_yet", {31'b0, INT_PENDING}, 32'h0);
    tick();  chk("irq_ext_pending", {31'b0, INT_PENDING}, 32'h1);
             chk("irq_ext_cause", INT_CAUSE, 32'h8000_000B);
    INT_SOFT = 1;
    tick();  chk("irq_ext_over_soft", INT_CAUSE, 32'h8000_000B);
    INT_EXT = 0; INT_TIMER = 1;
    tick();  chk("irq_soft_over_timer", INT_CAUSE, 32'h8000_0003);

    // Trap entry with a colliding CSR write, then MRET.
    TRAP_EN = 1; TRAP_PC = 32'h1003; TRAP_CODE = 32'h2; TRAP_VAL = 32'hDEAD;
    WREN = 1; WADDR = 12'h340; WDATA = 32'h5555;
    tick();
    TRAP_EN = 0; WREN = 0; WADDR = 0; WDATA = 0;
    chk("trap_ret_pc", RET_PC, 32'h1000);
    chk("trap_masks_irq", {31'b0, INT_PENDING}, 32'h0);
    rd(12'h342); chk("trap_mcause", RDATA, 32'h2);
    rd(12'h343); chk("trap_mtval", RDATA, 32'hDEAD);
    rd(12'h300); chk("trap_mstatus", RDATA, 32'h1880);
    rd(12'h340); chk("trap_scratch_kept", RDATA, 32'hAAAA);
    CHMODE_DO = 1;
    tick();
    CHMODE_DO = 0;
    rd(12'h300); chk("mret_mstatus", RDATA, 32'h1888);
                 chk("mret_ret_pc", RET_PC, 32'h1000);
    INT_SOFT = 0; INT_TIMER = 0;

    // Forwarding and pipeline control.
    RADDR = 12'h305; FWD_EXEC_ADDR = 12'h305; FWD_EXEC_EN = 1; FWD_EXEC_DATA = 32'h100;
    tick();  chk("fwd_exec_data", RDATA, 32'h100);
    FWD_EXEC_EN = 0;
    tick();  chk("fwd_exec_disabled", {31'b0, RVALID}, 32'h0);
    FWD_EXEC_ADDR = 0; FWD_CSR_ADDR = 12'h305;
    tick();  chk("fwd_csr_busy", {31'b0, RVALID}, 32'h0);
    STALL = 1; RADDR = 12'h343;
    tick();  chk("stall_valid", {31'b0, RVALID}, 32'h1);
             chk("stall_raddr_held", RDATA, 32'h0);
    STALL = 0; MMU_WAIT = 1;
    tick();  chk("mmu_wait_held", RDATA, 32'h0);
    MMU_WAIT = 0;
    tick();  chk("resume_read", RDATA, 32'hDEAD);
    FWD_CSR_ADDR = 0; FLUSH = 1;
    tick();  chk("flush_clears", RDATA, 32'h0);
    FLUSH = 0;
    RADDR = 12'h340; FWD_EXEC_ADDR = 12'h340; FWD_EXEC_EN = 1; FWD_EXEC_DATA = 32'h66;
    FWD_CUSHION_ADDR = 12'h340; FWD_CUSHION_EN = 1; FWD_CUSHION_DATA = 32'h55;
    tick();  chk("exec_over_cushion", RDATA, 32'h66);
    FWD_EXEC_ADDR = 0; FWD_EXEC_EN = 0;
    tick();  chk("cushion_data", RDATA, 32'h55);
    FWD_CUSHION_EN = 0;
    tick();  chk("cushion_disabled", {31'b0, RVALID}, 32'h0);
    FWD_CUSHION_ADDR = 0;
    tick();  chk("arch_after_fwd", RDATA, 32'hAAAA);

    // mtvec / mepc write masking.
    wr(12'h305, 32'h0000_1003);
    chk("mtvec_mode3", {30'b0, TRAP_VEC_MODE}, 32'h0);
    chk("mtvec_base", TRAP_VEC_BASE, 32'h1000);
    wr(12'h305, 32'h0000_2001);
    chk("mtvec_mode1", {30'b0, TRAP_VEC_MODE}, 32'h1);
    wr(12'h341, 32'h0000_3007);
    chk("mepc_align", RET_PC, 32'h3004);
    wr(12'h301, 32'hFFFF_FFFF);
    wr(12'hC00, 32'h1234);
    wr(12'h344, 32'hFFFF_FFFF);
    wr(12'hB82, 32'h7);
    foreach (Sweep[i]) rd(Sweep[i]);
    rd(12'hF14); chk("mhartid", RDATA, 32'h0);
    rd(12'h301); chk("misa", RDATA, 32'h4000_0100);

    // Asynchronous reset in the middle of a cycle.
    RADDR = 12'hB00;
    tick();
    #2 RST_N = 0;
    #1 chk("async_rst_rdata", RDATA, 32'h0);
       chk("async_rst_vec", TRAP_VEC_BASE, 32'h0);
       chk("async_rst_ret_pc", RET_PC, 32'h0);
    @(posedge CLK);
    #1 RST_N = 1;
    tick();      chk("post_rst_mcycle", RDATA, 32'h1);
    rd(12'hB82); chk("post_rst_minstreth", RDATA, 32'h0);
    tick();
    @(negedge CLK);
    #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
